// File: rtl/fp_wire.sv
// Shared FP wire definitions: execution-unit bus types and arbiter request/state types.
package fp_wire;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned FLAGS_W = 5;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned FMT_W   = 2;
  localparam int unsigned RM_W    = 3;

  localparam logic [OP_W-1:0] FP_OP_FADD  = 5'd0;
  localparam logic [OP_W-1:0] FP_OP_FSUB  = 5'd1;
  localparam logic [OP_W-1:0] FP_OP_FMUL  = 5'd2;
  localparam logic [OP_W-1:0] FP_OP_FDIV  = 5'd3;
  localparam logic [OP_W-1:0] FP_OP_FSQRT = 5'd4;

  // Operation as presented by a requester
  typedef struct packed {
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [XLEN-1:0]  data3;
    logic [OP_W-1:0]  op;
    logic [FMT_W-1:0] fmt;
    logic [RM_W-1:0]  rm;
  } fp_arb_req_type;

  localparam fp_arb_req_type init_fp_arb_req = '0;

  // Drive towards the execution unit
  typedef struct packed {
    logic             enable;
    logic [XLEN-1:0]  data1;
    logic [XLEN-1:0]  data2;
    logic [XLEN-1:0]  data3;
    logic [OP_W-1:0]  op;
    logic [FMT_W-1:0] fmt;
    logic [RM_W-1:0]  rm;
  } fp_exe_in_type;

  localparam fp_exe_in_type init_fp_exe_in = '0;

  // Return from the execution unit
  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [FLAGS_W-1:0] flags;
    logic               ready;
  } fp_exe_out_type;

  localparam fp_exe_out_type init_fp_exe_out = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fp_arb_state_type;

  // Build the execution-unit drive from a held request
  function automatic fp_exe_in_type fp_exe_drive(input fp_arb_req_type r, input logic en);
    fp_exe_in_type d;
    d        = init_fp_exe_in;
    d.enable = en;
    d.data1  = r.data1;
    d.data2  = r.data2;
    d.data3  = r.data3;
    d.op     = r.op;
    d.fmt    = r.fmt;
    d.rm     = r.rm;
    return d;
  endfunction

endpackage

// File: rtl/fp_arb_rr.sv
// Two-way round-robin grant: pointer breaks ties, a lone requester always wins.
module fp_arb_rr (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Grant selection
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ptr;
      gnt    = ptr ? 2'b10 : 2'b01;
    end else if (req[1]) begin
      gnt_id = 1'b1;
      gnt    = 2'b10;
    end else if (req[0]) begin
      gnt_id = 1'b0;
      gnt    = 2'b01;
    end
  end

endmodule

// File: rtl/fp_exe_arb.sv
// Two-requester arbiter in front of a single FP execution unit, one operation in flight.
// Optional feature: define FP_EXE_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module fp_exe_arb
  import fp_wire::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  fp_arb_req_type      req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  fp_arb_req_type      req1_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_id,
  output logic [XLEN-1:0]     resp_result,
  output logic [FLAGS_W-1:0]  resp_flags,
  output logic                resp_err,
  output fp_exe_in_type       fp_exe_i,
  input  fp_exe_out_type      fp_exe_o
);

  // A zero timeout would make the abort condition meaningless
  if (TIMEOUT == 0) begin : g_timeout_check
    $error("fp_exe_arb: TIMEOUT must be at least 1");
  end

  fp_arb_state_type   state;
  logic               ptr;
  fp_arb_req_type     hold;
  logic               hold_id;
  logic               resp_id_q;
  logic [XLEN-1:0]    resp_result_q;
  logic [FLAGS_W-1:0] resp_flags_q;
  logic [1:0]         gnt;
  logic               gnt_id;

`ifdef FP_EXE_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 1024) ? 10 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             resp_err_q;
`endif

  fp_arb_rr u_rr (
    .req    ({req1_valid, req0_valid}),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Arbitration, issue and response sequencing
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      hold          <= init_fp_arb_req;
      hold_id       <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
`ifdef FP_EXE_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      resp_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            hold    <= gnt[1] ? req1_data : req0_data;
            hold_id <= gnt_id;
            ptr     <= ~gnt_id;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef FP_EXE_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (fp_exe_o.ready) begin
            resp_id_q     <= hold_id;
            resp_result_q <= fp_exe_o.result;
            resp_flags_q  <= fp_exe_o.flags;
`ifdef FP_EXE_ARB_TIMEOUT_EN
            resp_err_q    <= 1'b0;
`endif
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (fp_exe_o.ready) begin
            resp_id_q     <= hold_id;
            resp_result_q <= fp_exe_o.result;
            resp_flags_q  <= fp_exe_o.flags;
`ifdef FP_EXE_ARB_TIMEOUT_EN
            resp_err_q    <= 1'b0;
`endif
            state         <= RESP;
          end
`ifdef FP_EXE_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_id_q     <= hold_id;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_err_q    <= 1'b1;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs, forced low while reset is held
  assign req0_ready  = (state == IDLE) && !reset && gnt[0];
  assign req1_ready  = (state == IDLE) && !reset && gnt[1];
  assign resp_valid  = (state == RESP) && !reset;
  assign resp_id     = resp_id_q && !reset;
  assign resp_result = reset ? '0 : resp_result_q;
  assign resp_flags  = reset ? '0 : resp_flags_q;
`ifdef FP_EXE_ARB_TIMEOUT_EN
  assign resp_err    = resp_err_q && !reset;
`else
  assign resp_err    = 1'b0;
`endif

  // Execution-unit drive: enable pulses in ISSUE, operands held through WAIT
  always_comb begin
    fp_exe_i = init_fp_exe_in;
    if (!reset && ((state == ISSUE) || (state == WAIT))) begin
      fp_exe_i = fp_exe_drive(hold, state == ISSUE);
    end
  end

endmodule

// File: tb/tb_fp_exe_arb.sv
// Directed self-checking bench for fp_exe_arb with a stub execution unit.
module tb_fp_exe_arb;
  import fp_wire::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  fp_arb_req_type     req0_data, req1_data;
  logic               resp_valid, resp_ready, resp_id, resp_err;
  logic [63:0]        resp_result;
  logic [4:0]         resp_flags;
  fp_exe_in_type      fp_exe_i;
  fp_exe_out_type     fp_exe_o;

  logic               echo, exe_ready_drv, sum_mode;
  logic [63:0]        fixed_result;
  logic [4:0]         fixed_flags;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fp_exe_arb #(.TIMEOUT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_data   (req1_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_err    (resp_err),
    .fp_exe_i    (fp_exe_i),
    .fp_exe_o    (fp_exe_o)
  );

  // Stub execution unit: either echoes enable as ready or follows a driven ready
  always_comb begin
    fp_exe_o        = init_fp_exe_out;
    fp_exe_o.ready  = echo ? fp_exe_i.enable : exe_ready_drv;
    fp_exe_o.result = sum_mode ? (fp_exe_i.data1 + fp_exe_i.data2) : fixed_result;
    fp_exe_o.flags  = fixed_flags;
  end

  function automatic fp_arb_req_type mk(input logic [63:0] d1, input logic [63:0] d2,
                                        input logic [63:0] d3, input logic [4:0] op,
                                        input logic [2:0] rm);
    fp_arb_req_type r;
    r       = init_fp_arb_req;
    r.data1 = d1;
    r.data2 = d2;
    r.data3 = d3;
    r.op    = op;
    r.fmt   = 2'b00;
    r.rm    = rm;
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; exe_ready_drv = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_err, fp_exe_i.enable} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_early got %b expected 000000",
        {req0_ready, req1_ready, resp_valid, resp_id, resp_err, fp_exe_i.enable});
    end
    tick(); tick();
    checks++;
    if ({req0_ready, req1_ready, resp_valid, resp_id, resp_err, fp_exe_i.enable} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b expected 000000",
        {req0_ready, req1_ready, resp_valid, resp_id, resp_err, fp_exe_i.enable});
    end
    checks++;
    if ({resp_result, resp_flags} !== 69'h0) begin
      errors++; $display("FAIL reset_data got %h expected 0", {resp_result, resp_flags});
    end
    req0_valid = 1'b0; req1_valid = 1'b0; exe_ready_drv = 1'b0; reset = 1'b0;
    tick();
    checks++;
    if ({req0_ready, req1_ready, resp_valid} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b expected 000", {req0_ready, req1_ready, resp_valid});
    end
  endtask

  task automatic test_single();
    echo = 1'b1; sum_mode = 1'b0; fixed_result = 64'h40400000; fixed_flags = 5'b0; resp_ready = 1'b1;
    req0_data = mk(64'h3F800000, 64'h40000000, 64'h0, FP_OP_FADD, 3'b000);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_accept got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++;
    if ({fp_exe_i.enable, fp_exe_i.data1, fp_exe_i.data2, fp_exe_i.op, resp_valid} !==
        {1'b1, 64'h3F800000, 64'h40000000, FP_OP_FADD, 1'b0}) begin
      errors++; $display("FAIL single_issue got en=%b d1=%h d2=%h rv=%b expected en=1 d1=3f800000 d2=40000000 rv=0",
        fp_exe_i.enable, fp_exe_i.data1, fp_exe_i.data2, resp_valid);
    end
    tick();
    checks++;
    if ({resp_valid, resp_id, resp_err, fp_exe_i.enable} !== 4'b1000 || resp_result !== 64'h40400000 ||
        resp_flags !== 5'b0) begin
      errors++; $display("FAIL single_resp got v=%b id=%b err=%b en=%b res=%h fl=%b expected v=1 id=0 err=0 en=0 res=40400000 fl=0",
        resp_valid, resp_id, resp_err, fp_exe_i.enable, resp_result, resp_flags);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL single_done got %b expected 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic exp_id;
    reset = 1'b1; tick(); reset = 1'b0;
    echo = 1'b1; sum_mode = 1'b1; resp_ready = 1'b1;
    req0_data = mk(64'h11, 64'h22, 64'h0, FP_OP_FADD, 3'b000);
    req1_data = mk(64'h1000, 64'h2000, 64'h0, FP_OP_FMUL, 3'b000);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = 1'(i % 2);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant op%0d got %b expected %b", i, {req1_ready, req0_ready},
          exp_id ? 2'b10 : 2'b01);
      end
      tick();
      checks++;
      if ({req1_ready, req0_ready, fp_exe_i.enable} !== 3'b001) begin
        errors++; $display("FAIL rr_issue op%0d got %b expected 001", i, {req1_ready, req0_ready, fp_exe_i.enable});
      end
      tick();
      checks++;
      if ({req1_ready, req0_ready, resp_valid, resp_id} !== {3'b001, exp_id} ||
          resp_result !== (exp_id ? 64'h3000 : 64'h33)) begin
        errors++; $display("FAIL rr_resp op%0d got rdy=%b v=%b id=%b res=%h expected rdy=00 v=1 id=%b res=%h",
          i, {req1_ready, req0_ready}, resp_valid, resp_id, resp_result, exp_id, exp_id ? 64'h3000 : 64'h33);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_multicycle();
    logic [200:0] exp_ops;
    exp_ops = {64'h3F800000, 64'h40000000, 64'h5, FP_OP_FDIV, 2'b00, 3'b001};
    echo = 1'b0; exe_ready_drv = 1'b0; sum_mode = 1'b0;
    fixed_result = 64'h3F000000; fixed_flags = 5'b00001;
    req0_data = mk(64'h3F800000, 64'h40000000, 64'h5, FP_OP_FDIV, 3'b001);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL mc_accept got %b expected 10", {req0_ready, req1_ready});
    end
    tick();
    req0_valid = 1'b0; req0_data = init_fp_arb_req;
    checks++;
    if (fp_exe_i.enable !== 1'b1) begin
      errors++; $display("FAIL mc_issue got %b expected 1", fp_exe_i.enable);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({fp_exe_i.enable, resp_valid} !== 2'b00 ||
          {fp_exe_i.data1, fp_exe_i.data2, fp_exe_i.data3, fp_exe_i.op, fp_exe_i.fmt, fp_exe_i.rm} !== exp_ops) begin
        errors++; $display("FAIL mc_wait cycle%0d got en=%b rv=%b ops=%h expected en=0 rv=0 ops=%h",
          i + 1, fp_exe_i.enable, resp_valid,
          {fp_exe_i.data1, fp_exe_i.data2, fp_exe_i.data3, fp_exe_i.op, fp_exe_i.fmt, fp_exe_i.rm}, exp_ops);
      end
      if (i == 19) exe_ready_drv = 1'b1;
      tick();
    end
    exe_ready_drv = 1'b0;
    checks++;
    if ({resp_valid, resp_id, fp_exe_i.enable} !== 3'b100 || resp_result !== 64'h3F000000 ||
        resp_flags !== 5'b00001) begin
      errors++; $display("FAIL mc_resp got v=%b id=%b en=%b res=%h fl=%b expected v=1 id=0 en=0 res=3f000000 fl=00001",
        resp_valid, resp_id, fp_exe_i.enable, resp_result, resp_flags);
    end
    tick();
  endtask

  task automatic test_backpressure();
    echo = 1'b1; sum_mode = 1'b0; fixed_result = 64'hABCD; fixed_flags = 5'b10000; resp_ready = 1'b0;
    req0_data = mk(64'h1, 64'h2, 64'h0, FP_OP_FADD, 3'b000);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_accept got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    req1_data = mk(64'h7, 64'h8, 64'h0, FP_OP_FSUB, 3'b010);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_id, req1_ready} !== 3'b100 || resp_result !== 64'hABCD || resp_flags !== 5'b10000) begin
        errors++; $display("FAIL bp_hold cycle%0d got v=%b id=%b r1=%b res=%h fl=%b expected v=1 id=0 r1=0 res=abcd fl=10000",
          i, resp_valid, resp_id, req1_ready, resp_result, resp_flags);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if ({resp_valid, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_handshake got %b expected 10", {resp_valid, req1_ready});
    end
    tick();
    checks++;
    if ({req1_ready, req0_ready, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL bp_next_accept got %b expected 100", {req1_ready, req0_ready, resp_valid});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({resp_valid, resp_id} !== 2'b11 || resp_result !== 64'hABCD) begin
      errors++; $display("FAIL bp_req1_resp got v=%b id=%b res=%h expected v=1 id=1 res=abcd",
        resp_valid, resp_id, resp_result);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    echo = 1'b0; exe_ready_drv = 1'b0; fixed_result = 64'h55; fixed_flags = 5'b0;
    req0_data = mk(64'h1, 64'h2, 64'h0, FP_OP_FADD, 3'b000);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rw_accept got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({fp_exe_i.enable, resp_valid, req0_ready, req1_ready} !== 4'b0000) begin
      errors++; $display("FAIL rw_during_reset got %b expected 0000",
        {fp_exe_i.enable, resp_valid, req0_ready, req1_ready});
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    exe_ready_drv = 1'b1;
    tick();
    exe_ready_drv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({resp_valid, fp_exe_i.enable} !== 2'b00) begin
        errors++; $display("FAIL rw_no_resp cycle%0d got %b expected 00", i, {resp_valid, fp_exe_i.enable});
      end
      tick();
    end
    echo = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      errors++; $display("FAIL rw_ptr_zero got %b expected 01", {req1_ready, req0_ready});
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    echo = 1'b0; exe_ready_drv = 1'b0; sum_mode = 1'b0; resp_ready = 1'b1;
    fixed_result = 64'hDEAD; fixed_flags = 5'b00100;
    req0_data = mk(64'h9, 64'h3, 64'h0, FP_OP_FDIV, 3'b000);
`ifdef FP_EXE_ARB_TIMEOUT_EN
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (resp_valid !== 1'b0) begin
        errors++; $display("FAIL to_wait cycle%0d got %b expected 0", i + 1, resp_valid);
      end
      tick();
    end
    checks++;
    if ({resp_valid, resp_err} !== 2'b11 || resp_result !== 64'h0 || resp_flags !== 5'b0) begin
      errors++; $display("FAIL to_abort got v=%b err=%b res=%h fl=%b expected v=1 err=1 res=0 fl=0",
        resp_valid, resp_err, resp_result, resp_flags);
    end
    tick();
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    exe_ready_drv = 1'b1;
    tick();
    exe_ready_drv = 1'b0;
    checks++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_result !== 64'hDEAD || resp_flags !== 5'b00100) begin
      errors++; $display("FAIL to_ready_wins got v=%b err=%b res=%h fl=%b expected v=1 err=0 res=dead fl=00100",
        resp_valid, resp_err, resp_result, resp_flags);
    end
    tick();
`else
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({resp_valid, resp_err} !== 2'b00) begin
        errors++; $display("FAIL nto_wait cycle%0d got %b expected 00", i + 1, {resp_valid, resp_err});
      end
      tick();
    end
    exe_ready_drv = 1'b1;
    tick();
    exe_ready_drv = 1'b0;
    checks++;
    if ({resp_valid, resp_err} !== 2'b10 || resp_result !== 64'hDEAD) begin
      errors++; $display("FAIL nto_resp got v=%b err=%b res=%h expected v=1 err=0 res=dead",
        resp_valid, resp_err, resp_result);
    end
    tick();
`endif
  endtask

  initial begin
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = init_fp_arb_req; req1_data = init_fp_arb_req;
    resp_ready = 1'b1; echo = 1'b0; exe_ready_drv = 1'b0; sum_mode = 1'b0;
    fixed_result = 64'h0; fixed_flags = 5'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_multicycle();
    test_backpressure();
    test_reset_in_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
